serial_comparator_fsm: RTL and testbench
========================================

SERIAL_COMPARATOR_FSM -- requirements
Module: serial_comparator_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to compare a and b.
REQ-005 SHALL have port a, input, WIDTH bits: first operand, unsigned, sampled only on start acceptance.
REQ-006 SHALL have port b, input, WIDTH bits: second operand, unsigned, sampled only on start acceptance.
REQ-007 SHALL have port busy, output, 1 bit: high while a comparison is in progress (COMPARE state).
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse indicating that the result outputs are valid.
REQ-009 SHALL have port a_maior_que_b, output, 1 bit, registered: high when a > b.
REQ-010 SHALL have port a_menor_que_b, output, 1 bit, registered: high when a < b.
REQ-011 SHALL have port a_igual_b, output, 1 bit, registered: high when a == b.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, COMPARE, DONE.
REQ-013 IDLE with start=1 at a rising edge SHALL perform all of the following:
- load the a and b shift registers;
- load bit counter = WIDTH-1;
- clear all three result outputs;
- go to COMPARE.
REQ-014 In COMPARE, each cycle SHALL compare the current MSB of both shift registers with one 1-bit comparison.
REQ-015 In COMPARE, if the bit compare gives greater or less, then at the next edge the FSM SHALL:
- set the matching result output;
- go to DONE (early termination, no further shifting).
REQ-016 In COMPARE, if the bits are equal and counter != 0, then at the next edge the FSM SHALL:
- shift both registers left by 1;
- decrement the counter;
- stay in COMPARE.
REQ-017 In COMPARE, if the bits are equal and counter == 0, then at the next edge the FSM SHALL set a_igual_b and go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: done SHALL be high m cycles after the accepting edge.
- m = WIDTH - i, where i is the index of the most significant differing bit.
- m = WIDTH when a == b.
REQ-020 Result outputs SHALL hold their value from the DONE transition until the next accepted start, or until reset.
REQ-021 Result outputs SHALL be at most one-hot at all times; after reset and between acceptance and result they are all 0.
REQ-022 start SHALL be ignored in COMPARE and DONE, with no effect on state, operands or results.
- A start coincident with done is dropped.
REQ-023 Changes on a or b after acceptance SHALL NOT affect the running comparison.
REQ-024 busy SHALL be a decode of state == COMPARE; done SHALL be a decode of state == DONE.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force all of the following, regardless of clk:
- state = IDLE;
- busy = 0, done = 0;
- all three result outputs = 0;
- shift registers = 0, counter = 0.
REQ-026 Reset asserted mid-COMPARE SHALL abort the comparison with no done pulse and no partial result.
REQ-027 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-028 The state encoding localparams (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared package/include file.
REQ-029 Per-bit comparison SHALL be done by one instance of the existing gate-level 1-bit comparator sub-module, comparator_1bit_struct, driven by the shift-register MSBs.
REQ-030 The counter SHALL be $clog2(WIDTH) bits wide; encoding 2'd3 SHALL fall back to IDLE.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover these directed scenarios:
- a=8'hA5, b=8'h25, start pulse -> a_maior_que_b=1, others 0; done 1 cycle after the accepting edge; busy high 1 cycle.
- a=8'h10, b=8'h11 -> a_menor_que_b=1; done 8 cycles after acceptance.
- a=b=8'h3C -> a_igual_b=1; done 8 cycles after acceptance; results held for 5 idle cycles afterwards.
- Start a=8'h01, b=8'h02; on the 3rd busy cycle pulse start again with a=8'hFF, b=8'h00 -> second start ignored; result a_menor_que_b=1.
- Start a=8'h01, b=8'h03; assert rst on the 4th busy cycle -> all outputs 0 immediately; no done pulse; a new start after reset gives a correct result.
- Start held high continuously with a=8'h80, b=8'h7F -> a compare every 3 cycles (IDLE, COMPARE, DONE); a_maior_que_b=1 each time.

Source files
------------

// File: rtl/serial_comparator_fsm_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   WIDTH_DEFAULT : default operand width
//   IDLE/COMPARE/DONE : state encodings, also exposed as the state_e enum
package serial_comparator_fsm_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_COMPARE = COMPARE,
    ST_DONE    = DONE
  } state_e;

endpackage

// File: rtl/comparator_1bit_struct.sv
// Gate-level 1-bit magnitude comparator.
//   a, b : input bits
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module comparator_1bit_struct (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  logic a_n;
  logic b_n;

  not u_inv_a (a_n, a);
  not u_inv_b (b_n, b);
  and u_gt    (gt, a, b_n);
  and u_lt    (lt, a_n, b);
  nor u_eq    (eq, gt, lt);

endmodule

// File: rtl/serial_comparator_fsm.sv
// Serial MSB-first unsigned comparator. Operands are captured on an accepted
// start and compared one bit per cycle, terminating at the first differing bit.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle compare request (honoured only in IDLE)
//   a, b            : operands, sampled on acceptance
//   busy            : comparison in progress
//   done            : one-cycle pulse, results valid
//   a_maior_que_b   : a > b  (held until next accepted start)
//   a_menor_que_b   : a < b
//   a_igual_b       : a == b
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start; results hold last outcome
// COMPARE  | one MSB pair examined per cycle
// DONE     | done pulse; returns to IDLE
module serial_comparator_fsm
  import serial_comparator_fsm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_maior_que_b,
  output logic             a_menor_que_b,
  output logic             a_igual_b
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic bit_gt;
  logic bit_lt;
  logic bit_eq;

  comparator_1bit_struct u_cmp (
    .a  (sh_a_q[WIDTH-1]),
    .b  (sh_b_q[WIDTH-1]),
    .gt (bit_gt),
    .lt (bit_lt),
    .eq (bit_eq)
  );

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          cnt_d   = CNT_W'(WIDTH - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        // The first differing MSB decides; remaining bits are never examined.
        if (bit_gt) begin
          gt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (bit_lt) begin
          lt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (bit_eq) begin
          if (cnt_q != '0) begin
            sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
            sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q - 1'b1;
          end else begin
            eq_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy          = (state_q == ST_COMPARE);
  assign done          = (state_q == ST_DONE);
  assign a_maior_que_b = gt_q;
  assign a_menor_que_b = lt_q;
  assign a_igual_b     = eq_q;

endmodule

// File: tb/tb_serial_comparator_fsm.sv
module tb_serial_comparator_fsm;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       gt;
  logic       lt;
  logic       eq;

  int compared;
  int mismatched;

  serial_comparator_fsm #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .a_maior_que_b (gt),
    .a_menor_que_b (lt),
    .a_igual_b     (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from acceptance to done: WIDTH minus index of the top differing bit.
  function automatic int model_lat(input logic [7:0] x, input logic [7:0] y);
    if (x == y) return 8;
    for (int i = 7; i >= 0; i--)
      if (x[i] != y[i]) return 8 - i;
    return 8;
  endfunction

  function automatic logic [2:0] model_res(input logic [7:0] x, input logic [7:0] y);
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  // One comparison. inject_k: busy-cycle index at which a stray start is pulsed.
  // rst_k: busy-cycle index at which reset is asserted (comparison aborted).
  task automatic run_case(input logic [7:0] ta, input logic [7:0] tbv,
                          input int inject_k, input int rst_k);
    int m;
    int k;
    int busy_cnt;
    logic [2:0] exp_res;
    m       = model_lat(ta, tbv);
    exp_res = model_res(ta, tbv);
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    chk("cleared_on_accept", {29'd0, gt, lt, eq}, 32'd0);
    k = 0;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        @(negedge clk);
        chk("reset_held_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("no_done_after_abort", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        return;
      end
      if (k == inject_k) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else if (k == inject_k + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("latency", k, m);
    chk("busy_cycles", busy_cnt, m);
    chk("result", {29'd0, gt, lt, eq}, {29'd0, exp_res});
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("result_held", {29'd0, gt, lt, eq}, {29'd0, exp_res});
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    #2;
    chk("reset_state", {27'd0, busy, done, gt, lt, eq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case(8'hA5, 8'h25, -1, -1);
    run_case(8'h10, 8'h11, -1, -1);

    run_case(8'h3C, 8'h3C, -1, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("eq_hold_idle", {30'd0, eq, done}, 32'd2);
    end

    run_case(8'h01, 8'h02, 2, -1);

    run_case(8'h01, 8'h03, -1, 3);
    run_case(8'h01, 8'h03, -1, -1);

    // Continuous start: accept, compare, done repeats every 3 cycles.
    @(negedge clk);
    a = 8'h80; b = 8'h7F; start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      int p;
      @(negedge clk);
      p = (k - 1) % 3;
      chk("cont_busy", {31'd0, busy}, (p == 0) ? 32'd1 : 32'd0);
      chk("cont_done", {31'd0, done}, (p == 1) ? 32'd1 : 32'd0);
      chk("cont_result", {29'd0, gt, lt, eq}, (p == 0) ? 32'd0 : 32'd4);
    end
    start = 1'b0;
    @(negedge clk);
    chk("cont_stopped", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run_case(ra, rb, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
